bit_stuffer: RTL and testbench
==============================

Name: bit_stuffer

Overview:
- Serial USB bit-stuffing stage. It sits directly downstream of the CRC encoder/PISO (consumes its serial bit stream and outbound-valid) and upstream of the NRZI encoder.
- After STUFF_LEN consecutive 1s it inserts a single 0 and stalls the producer for that one cycle via readyIn.
- It reports the end of each packet and counts the stuff bits inserted per packet.

Parameters:
- STUFF_LEN, 6: number of consecutive 1s that triggers insertion of one 0 (legal range 2..15).
- CNT_W, 8: width of stuffCount (saturating).

Ports:
- clk  input  1  system clock, all state on posedge.
- rst_b  input  1  asynchronous active-low reset.
- bIn  input  1  serial data bit from the upstream encoder.
- inAvail  input  1  bIn valid. A high level across consecutive cycles is one packet.
- readyIn  output  1  stuffer accepts bIn this cycle. Combinational: low only in STUFF.
- bOut  output  1  registered serial output bit.
- outAvail  output  1  registered; bOut valid.
- pktDone  output  1  one-cycle pulse in the cycle after the last valid output bit of a packet.
- stuffCount  output  CNT_W  stuff bits inserted in the current or most recent packet, saturating at all-ones.

Behaviour:
- Reset (rst_b low, asynchronous):
  - state=IDLE, onesCnt=0.
  - bOut=0, outAvail=0, pktDone=0, stuffCount=0.
  - readyIn reads 1 after reset.
- Transfer: a bit is accepted at a posedge where inAvail && readyIn.
- Upstream contract: hold bIn stable while inAvail && !readyIn.
- Latency: an accepted bit appears on bOut/outAvail one cycle after the accepting edge.
- onesCnt (internal, 4 bits):
  - +1 on an accepted 1.
  - Cleared on an accepted 0, on the stuff edge, and at packet end.
- States are IDLE, SEND and STUFF. pktDone is 0 at every edge not listed below.
- IDLE:
  - Transfer: bOut<=bIn, outAvail<=1, stuffCount<=0 (new packet), onesCnt updated. Next state is SEND, or STUFF if the trigger below fires.
  - No transfer: outAvail<=0, bOut<=0, stay in IDLE.
- SEND:
  - Transfer: same as IDLE but stuffCount is not cleared.
  - No inAvail: packet end. outAvail<=0, bOut<=0, pktDone<=1, onesCnt<=0, next state IDLE.
- Stuff trigger: an accepted bIn==1 while onesCnt==STUFF_LEN-1 moves the state to STUFF at that edge. That edge loads the STUFF_LEN-th 1 into bOut.
- STUFF:
  - readyIn=0 and inAvail is ignored.
  - Next edge: bOut<=0, outAvail<=1, onesCnt<=0, stuffCount<=sat(stuffCount+1), next state SEND.
- End-of-packet stuffing: if the last accepted bit completes a run of STUFF_LEN ones, the stuff 0 is still emitted after inAvail falls. pktDone follows the stuff bit.
- Gap: a single cycle with inAvail low in SEND ends the packet. A following assertion starts a new packet with onesCnt=0 and stuffCount cleared.
- A run of ones does not carry across packets.
- stuffCount holds its value after pktDone until the next packet's first transfer.
- Mid-packet reset: everything returns to reset values immediately.
  - No pktDone is issued for the aborted packet.
  - Any pending stuff bit is discarded.

Test Plan:
1. One packet of 8 ones then a 0 (9 bits) -> bOut=1,1,1,1,1,1,0,1,1,0 over 10 outAvail cycles. readyIn low for exactly one cycle, the cycle after the 6th 1 is accepted. stuffCount=1. pktDone one cycle after the last bit.
2. Packet 1,1,1,1,1,0,1 -> output identical to input (7 bits). readyIn never low. stuffCount=0.
3. Packet of exactly six 1s -> 7 outAvail cycles: six 1s then 0. pktDone in the 8th cycle after the first bit appears. stuffCount=1.
4. Packet of 12 ones -> 14 output bits: 111111 0 111111 0. Two readyIn stall cycles. stuffCount=2.
5. Assert rst_b low during STUFF, then send 5 ones -> all outputs 0 during reset, no pktDone for the aborted packet. The following 5 ones pass with no stuff and stuffCount=0.
6. 3 ones, 1-cycle inAvail gap, 3 ones -> no stuff bit inserted. Two separate pktDone pulses. stuffCount=0 after each packet.

Source files
------------

// File: rtl/bit_stuffer_if.sv
// bit_stuffer_if: serial stream bundle around the USB bit stuffer.
//   bIn/inAvail/readyIn : upstream serial bit, valid, and stall back-pressure
//   bOut/outAvail       : stuffed serial bit and its valid, toward NRZI
//   pktDone             : one-cycle end-of-packet pulse
//   stuffCount          : stuff bits inserted in the current/last packet
// master = stream producer/observer side, slave = the stuffer itself.
interface bit_stuffer_if #(
  parameter int CNT_W = 8
);
  logic             bIn;
  logic             inAvail;
  logic             readyIn;
  logic             bOut;
  logic             outAvail;
  logic             pktDone;
  logic [CNT_W-1:0] stuffCount;

  modport master (
    output bIn, inAvail,
    input  readyIn, bOut, outAvail, pktDone, stuffCount
  );

  modport slave (
    input  bIn, inAvail,
    output readyIn, bOut, outAvail, pktDone, stuffCount
  );
endinterface

// File: rtl/bit_stuffer.sv
// bit_stuffer: USB bit-stuffing stage between the CRC/PISO and NRZI encoder.
// After STUFF_LEN consecutive accepted 1s a single 0 is inserted; the
// producer is stalled (readyIn low) for that one cycle. Output is registered,
// one cycle behind the accepting edge.
//   clk   : system clock, all state on posedge
//   rst_b : asynchronous active-low reset
//   bus   : slave side of bit_stuffer_if (stream in/out, pktDone, stuffCount)
module bit_stuffer #(
  parameter int STUFF_LEN = 6,
  parameter int CNT_W     = 8
) (
  input  logic          clk,
  input  logic          rst_b,
  bit_stuffer_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SEND  = 2'd1;
  localparam logic [1:0] STUFF = 2'd2;

  localparam logic [3:0] TRIG = 4'(STUFF_LEN - 1);

  logic [1:0]       state;
  logic [3:0]       ones_cnt;
  logic             b_out;
  logic             out_avail;
  logic             pkt_done;
  logic [CNT_W-1:0] stuff_cnt;

  logic ready;
  logic xfer;

  assign ready = (state != STUFF);
  assign xfer  = bus.inAvail && ready;

  assign bus.readyIn    = ready;
  assign bus.bOut       = b_out;
  assign bus.outAvail   = out_avail;
  assign bus.pktDone    = pkt_done;
  assign bus.stuffCount = stuff_cnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      ones_cnt  <= '0;
      b_out     <= 1'b0;
      out_avail <= 1'b0;
      pkt_done  <= 1'b0;
      stuff_cnt <= '0;
    end else begin
      pkt_done <= 1'b0;
      case (state)
        IDLE, SEND: begin
          if (xfer) begin
            b_out     <= bus.bIn;
            out_avail <= 1'b1;
            // first bit of a packet restarts the per-packet count
            if (state == IDLE) stuff_cnt <= '0;
            if (bus.bIn) begin
              ones_cnt <= ones_cnt + 4'd1;
              // this edge emits the STUFF_LEN-th 1; the 0 follows next edge
              state    <= (ones_cnt == TRIG) ? STUFF : SEND;
            end else begin
              ones_cnt <= '0;
              state    <= SEND;
            end
          end else begin
            b_out     <= 1'b0;
            out_avail <= 1'b0;
            if (state == SEND) begin
              pkt_done <= 1'b1;
              ones_cnt <= '0;
              state    <= IDLE;
            end
          end
        end
        STUFF: begin
          // inAvail is ignored here; the producer holds its bit.
          // Returning to SEND lets a dropped inAvail still raise pktDone
          // after the stuff bit.
          b_out     <= 1'b0;
          out_avail <= 1'b1;
          ones_cnt  <= '0;
          if (stuff_cnt != {CNT_W{1'b1}}) stuff_cnt <= stuff_cnt + 1'b1;
          state     <= SEND;
        end
        default: begin
          state     <= IDLE;
          ones_cnt  <= '0;
          b_out     <= 1'b0;
          out_avail <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_stuffer.sv
module tb_bit_stuffer;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_b = 1'b0;

  always #5 clk = ~clk;

  bit_stuffer_if #(.CNT_W(CNT_W)) bus ();

  bit_stuffer #(.STUFF_LEN(6), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_miss = 0;

  // monitor: collects valid output bits and event cycles at negedge
  int   cyc = 0;
  logic out_q[$];
  int   out_cyc[$];
  int   done_cyc[$];
  int   stall_cyc[$];

  always @(negedge clk) begin
    if (bus.outAvail) begin
      out_q.push_back(bus.bOut);
      out_cyc.push_back(cyc);
    end
    if (bus.pktDone) done_cyc.push_back(cyc);
    if (!bus.readyIn) stall_cyc.push_back(cyc);
    cyc++;
  end

  int o0, d0, s0;

  task automatic snap();
    o0 = out_q.size();
    d0 = done_cyc.size();
    s0 = stall_cyc.size();
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  task automatic send_pkt(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      int w;
      @(negedge clk); #1;
      bus.inAvail = 1'b1;
      bus.bIn     = bits[i];
      w = 0;
      while (!bus.readyIn && w < 8) begin
        @(negedge clk); #1;
        w++;
      end
      if (w >= 8) begin
        n_miss++;
        $display("FAIL ready_timeout: readyIn stayed low %0d cycles, expected at most 1", w);
      end
    end
    @(negedge clk); #1;
    bus.inAvail = 1'b0;
    bus.bIn     = 1'b0;
  endtask

  task automatic check_pkt(input string nm, input logic [15:0] exp_out, input int exp_n,
                           input int exp_stalls, input int exp_cnt, input int exp_done);
    logic [15:0] got;
    int nb;
    got = '0;
    nb  = out_q.size() - o0;
    for (int i = 0; i < nb && i < 16; i++) got[i] = out_q[o0+i];
    chk({nm, " out_len"}, nb, exp_n);
    chk({nm, " out_bits"}, int'(got), int'(exp_out));
    chk({nm, " stalls"}, stall_cyc.size() - s0, exp_stalls);
    chk({nm, " pktDone_cnt"}, done_cyc.size() - d0, exp_done);
    chk({nm, " stuffCount"}, int'(bus.stuffCount), exp_cnt);
    if (exp_done > 0 && nb > 0 && done_cyc.size() > d0)
      chk({nm, " pktDone_after_last"}, done_cyc[done_cyc.size()-1] - out_cyc[out_cyc.size()-1], 1);
    if (exp_stalls > 0 && nb > 5 && stall_cyc.size() > s0)
      chk({nm, " stall_at_6th_one"}, stall_cyc[s0] - out_cyc[o0+5], 0);
  endtask

  typedef struct {
    string       name;
    logic [15:0] bits;     // LSB first
    int          n;
    logic [15:0] exp_out;  // LSB first
    int          exp_n;
    int          stalls;
    int          cnt;
  } vec_t;

  vec_t vecs[5];

  initial begin
    // 8 ones then 0 -> 111111 0 110
    vecs[0] = '{"eight_ones", 16'h00FF, 9,  16'h01BF, 10, 1, 1};
    // 11111 0 1 -> unchanged
    vecs[1] = '{"five_ones",  16'h005F, 7,  16'h005F, 7,  0, 0};
    // exactly six ones -> stuff after end of input
    vecs[2] = '{"six_ones",   16'h003F, 6,  16'h003F, 7,  1, 1};
    // twelve ones -> 111111 0 111111 0
    vecs[3] = '{"twelve_ones",16'h0FFF, 12, 16'h1FBF, 14, 2, 2};
    // all zeros -> unchanged
    vecs[4] = '{"zeros",      16'h0000, 3,  16'h0000, 3,  0, 0};

    bus.inAvail = 1'b0;
    bus.bIn     = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst readyIn",    int'(bus.readyIn), 1);
    chk("rst bOut",       int'(bus.bOut), 0);
    chk("rst outAvail",   int'(bus.outAvail), 0);
    chk("rst pktDone",    int'(bus.pktDone), 0);
    chk("rst stuffCount", int'(bus.stuffCount), 0);
    rst_b = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      snap();
      send_pkt(vecs[v].bits, vecs[v].n);
      repeat (5) @(negedge clk);
      #1;
      check_pkt(vecs[v].name, vecs[v].exp_out, vecs[v].exp_n, vecs[v].stalls, vecs[v].cnt, 1);
    end

    // mid-packet reset while in STUFF (second stuff of a long run of ones)
    begin
      int lows, w;
      snap();
      @(negedge clk); #1;
      bus.inAvail = 1'b1;
      bus.bIn     = 1'b1;
      lows = 0;
      w    = 0;
      while (lows < 2 && w < 40) begin
        @(negedge clk); #1;
        if (!bus.readyIn) lows++;
        w++;
      end
      chk("abort reached_second_stuff", lows, 2);
      chk("abort pre_reset_count", int'(bus.stuffCount), 1);
      rst_b = 1'b0;
      #1;
      chk("abort readyIn",    int'(bus.readyIn), 1);
      chk("abort bOut",       int'(bus.bOut), 0);
      chk("abort outAvail",   int'(bus.outAvail), 0);
      chk("abort pktDone",    int'(bus.pktDone), 0);
      chk("abort stuffCount", int'(bus.stuffCount), 0);
      bus.inAvail = 1'b0;
      bus.bIn     = 1'b0;
      @(negedge clk); #2;
      rst_b = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort no_pktDone", done_cyc.size() - d0, 0);
    end
    snap();
    send_pkt(16'h001F, 5);
    repeat (5) @(negedge clk);
    #1;
    check_pkt("post_reset", 16'h001F, 5, 0, 0, 1);

    // 3 ones, one-cycle gap, 3 ones: two packets, run does not carry over
    snap();
    begin
      logic [6:0] av;
      av = 7'b1110111;
      for (int i = 0; i < 7; i++) begin
        @(negedge clk); #1;
        bus.inAvail = av[i];
        bus.bIn     = av[i];
      end
    end
    @(negedge clk); #1;
    bus.inAvail = 1'b0;
    bus.bIn     = 1'b0;
    @(negedge clk); #1;
    // first packet's pulse must already be there, with count 0
    chk("gap first_count", int'(bus.stuffCount), 0);
    repeat (4) @(negedge clk);
    #1;
    check_pkt("gap", 16'h003F, 6, 0, 0, 2);
    if (done_cyc.size() - d0 == 2)
      chk("gap pulse_spacing", done_cyc[d0+1] - done_cyc[d0], 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
